// File: rtl/psum_accum_buffer_pkg.sv
// Shared types and helpers for the partial-sum accumulation buffer.
package psum_accum_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_ACC_WIDTH = 24;
    localparam int DEF_DEPTH     = 16;

    // Widest accumulator the saturating adder supports; ACC_WIDTH must stay below this.
    localparam int SAT_W = 32;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] sum;
    } sat_sum_t;

    function automatic sat_sum_t sat_add(input logic [SAT_W-1:0] a,
                                         input logic [SAT_W-1:0] b,
                                         input logic [SAT_W-1:0] lim);
        logic [SAT_W:0] s;
        sat_sum_t       r;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            r.sat = 1'b1;
            r.sum = lim;
        end else begin
            r.sat = 1'b0;
            r.sum = s[SAT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_accum_buffer_if.sv
// Partial-sum input stream and accumulated-result output stream.
interface psum_accum_buffer_if
    import psum_accum_buffer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
);
    logic [2*WIDTH-1:0]   in_psum;
    logic                 in_psum_vld;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_vld;
    logic                 out_rdy;

    modport master (
        output in_psum, in_psum_vld, out_rdy,
        input  out_data, out_vld
    );

    modport slave (
        input  in_psum, in_psum_vld, out_rdy,
        output out_data, out_vld
    );
endinterface

// File: rtl/psum_accum_buffer_ram.sv
// DEPTH x ACC_WIDTH register array: one write port, two asynchronous read ports.
module psum_buf_ram #(
    parameter int ACC_WIDTH = 24,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [ACC_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_a_i,
    output logic [ACC_WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]        raddr_b_i,
    output logic [ACC_WIDTH-1:0] rdata_b_o
);
    logic [ACC_WIDTH-1:0] mem_q [DEPTH];

    // No reset: the first pass of every tile overwrites each live entry.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/psum_accum_buffer.sv
// Accumulates PE partial sums per output pixel over several passes, then drains them.
// States: IDLE = wait for start | ACCUM = write/accumulate psums | DRAIN = stream results out
module psum_accum_buffer
    import psum_accum_buffer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LEN_W     = 5,
    parameter int PASS_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic [PASS_W-1:0] cfg_passes_i,
    psum_accum_buffer_if.slave bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o,
    output logic              drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);
    localparam logic [LEN_W-1:0]  DEPTH_L   = LEN_W'(DEPTH);
    localparam logic [SAT_W-1:0]  ACC_MAX   = SAT_W'({ACC_WIDTH{1'b1}});

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     pix_q, pix_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic [LEN_W-1:0]     rd_q, rd_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [PASS_W-1:0]    passes_q, passes_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_vld_q, out_vld_d;
    logic                 done_q, done_d;
    logic                 sat_q, sat_d;
    logic                 drop_q, drop_d;

    logic [2*WIDTH-1:0]   psum_in;
    logic [LEN_W-1:0]     len_m1;
    logic [PASS_W-1:0]    passes_m1;
    logic [LEN_W-1:0]     rd_next;
    logic                 drain_adv;
    logic                 wr_en;
    logic [ACC_WIDTH-1:0] wr_data;
    logic [ACC_WIDTH-1:0] rdata_a;
    logic [ACC_WIDTH-1:0] rdata_b;
    logic [AW-1:0]        raddr_b;
    sat_sum_t             acc_res;
    logic                 unused_hi;
    logic                 cfg_bad;

    assign psum_in   = bus.in_psum;
    assign len_m1    = len_q - LEN_ONE;
    assign passes_m1 = passes_q - PASS_ONE;
    assign rd_next   = rd_q + LEN_ONE;
    assign cfg_bad   = (cfg_len_i == '0) || (cfg_len_i > DEPTH_L) || (cfg_passes_i == '0);

    // Drain read port looks one entry ahead on a handshake so results stream at 1/cycle.
    assign drain_adv = (state_q == ST_DRAIN) && out_vld_q && bus.out_rdy && (rd_q != len_m1);
    assign raddr_b   = drain_adv ? rd_next[AW-1:0] : rd_q[AW-1:0];

    assign acc_res   = sat_add(SAT_W'(rdata_a), SAT_W'(psum_in), ACC_MAX);
    assign unused_hi = ^acc_res.sum[SAT_W-1:ACC_WIDTH];
    assign wr_en     = (state_q == ST_ACCUM) && bus.in_psum_vld;
    assign wr_data   = (pass_q == '0) ? ACC_WIDTH'(psum_in) : acc_res.sum[ACC_WIDTH-1:0];

    psum_buf_ram #(
        .ACC_WIDTH (ACC_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk       (clk),
        .we_i      (wr_en),
        .waddr_i   (pix_q[AW-1:0]),
        .wdata_i   (wr_data),
        .raddr_a_i (pix_q[AW-1:0]),
        .rdata_a_o (rdata_a),
        .raddr_b_i (raddr_b),
        .rdata_b_o (rdata_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pix_q      <= '0;
            pass_q     <= '0;
            rd_q       <= '0;
            len_q      <= '0;
            passes_q   <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            pass_q     <= pass_d;
            rd_q       <= rd_d;
            len_q      <= len_d;
            passes_q   <= passes_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        pass_d     = pass_q;
        rd_d       = rd_q;
        len_d      = len_q;
        passes_d   = passes_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        done_d     = 1'b0;
        sat_d      = sat_q;
        drop_d     = drop_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_psum_vld) begin
                    drop_d = 1'b1;
                end
                if (start_i) begin
                    len_d    = cfg_len_i;
                    passes_d = cfg_passes_i;
                    sat_d    = 1'b0;
                    drop_d   = 1'b0;
                    if (cfg_bad) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                        pix_d   = '0;
                        pass_d  = '0;
                    end
                end
            end

            ST_ACCUM: begin
                if (bus.in_psum_vld) begin
                    if ((pass_q != '0) && acc_res.sat) begin
                        sat_d = 1'b1;
                    end
                    if (pix_q == len_m1) begin
                        pix_d  = '0;
                        pass_d = pass_q + PASS_ONE;
                        if (pass_q == passes_m1) begin
                            state_d   = ST_DRAIN;
                            rd_d      = '0;
                            out_vld_d = 1'b0;
                        end
                    end else begin
                        pix_d = pix_q + LEN_ONE;
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.in_psum_vld) begin
                    drop_d = 1'b1;
                end
                if (!out_vld_q) begin
                    out_vld_d  = 1'b1;
                    out_data_d = rdata_b;
                end else if (bus.out_rdy) begin
                    if (rd_q == len_m1) begin
                        out_vld_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        rd_d       = rd_next;
                        out_data_d = rdata_b;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.out_data = out_data_q;
    assign bus.out_vld  = out_vld_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign sat_o        = sat_q;
    assign drop_o       = drop_q;
endmodule
